// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Default geometry and helpers shared by the pipelined carry adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_SEG   = 4;

    // Pipeline depth for a given word width and segment width.
    function automatic int stage_count(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_seg.sv
// ============================================================================
// Module  : carry_seg
// Brief   : SEG-bit combinational ripple-carry segment of full-adder cells.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module carry_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = w_c[SEG];
    assign c_msb = w_c[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_carry_adder.sv
// ============================================================================
// Module  : pipelined_carry_adder
// Brief   : WIDTH-bit adder, one SEG-bit carry segment per pipeline stage,
//           valid/ready streaming on both sides.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int SEG   = c_DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTG = stage_count(WIDTH, SEG);

    if (WIDTH % SEG != 0) begin : g_bad_geometry
        $error("pipelined_carry_adder: WIDTH must be a multiple of SEG");
    end

    typedef struct packed {
        logic             vld;
        logic             cy;
        logic             ovf;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t r_stg [NSTG];
    stage_t w_nxt [NSTG];
    logic   w_adv;

    // The whole pipe moves as one; only a stalled output can hold it.
    assign w_adv    = !r_stg[NSTG-1].vld | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        stage_t         w_src;
        stage_t         w_res;
        logic [SEG-1:0] w_s;
        logic           w_co;
        logic           w_cm;

        if (k == 0) begin : g_first
            assign w_src.vld = in_valid;
            assign w_src.cy  = c_in;
            assign w_src.ovf = 1'b0;
            assign w_src.s   = '0;
            assign w_src.a   = a;
            assign w_src.b   = b;
        end else begin : g_next
            assign w_src = r_stg[k-1];
        end

        carry_seg #(.SEG(SEG)) u_seg (
            .a     (w_src.a[k*SEG +: SEG]),
            .b     (w_src.b[k*SEG +: SEG]),
            .ci    (w_src.cy),
            .s     (w_s),
            .co    (w_co),
            .c_msb (w_cm)
        );

        // ovf is only meaningful out of the final stage, where w_cm is the MSB carry-in.
        always_comb begin
            w_res                  = w_src;
            w_res.s[k*SEG +: SEG]  = w_s;
            w_res.cy               = w_co;
            w_res.ovf              = w_cm ^ w_co;
        end

        assign w_nxt[k] = w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                r_stg[i] <= '0;
            end
        end else if (w_adv) begin
            for (int i = 0; i < NSTG; i++) begin
                r_stg[i] <= w_nxt[i];
            end
        end
    end

    assign out_valid = r_stg[NSTG-1].vld;
    assign sum       = r_stg[NSTG-1].s;
    assign c_out     = r_stg[NSTG-1].cy;
    assign ovf       = r_stg[NSTG-1].ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_carry_adder.sv
// ============================================================================
// Module  : tb_pipelined_carry_adder
// Brief   : Directed and random scoreboard bench for pipelined_carry_adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_carry_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [17:0] sb [$];

    logic        s_ovld;
    logic        s_irdy;
    logic [17:0] s_res;

    pipelined_carry_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {c_out, ovf, sum}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {t[16], v, t[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 unit later, score, wait next negedge.
    task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = ic;
        out_ready = ordy;
        #1;
        s_ovld = out_valid;
        s_irdy = in_ready;
        s_res  = {c_out, ovf, sum};
        if (!rst && out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("result", 32'(s_res), 32'(sb.pop_front()));
        end
        if (!rst && in_valid && in_ready) sb.push_back(model(ia, ib, ic));
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, ordy);
    endtask

    task automatic run_one(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                           input logic [17:0] exp, input string tag);
        int lat;
        cycle(1'b1, ia, ib, ic, 1'b1);
        lat = 0;
        do begin
            idle(1'b1);
            lat++;
        end while (!s_ovld && lat < 12);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_value"}, 32'(s_res), 32'(exp));
        idle(1'b1);
        chk({tag, "_one_cycle"}, 32'(s_ovld), 32'd0);
    endtask

    initial begin
        logic [15:0] mask;
        logic [17:0] snap;
        int          pops;
        int          acc;
        int          cyc;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        repeat (3) idle(1'b0);
        rst = 1'b0;
        sb.delete();

        // Reset state
        idle(1'b0);
        chk("rst_out_valid", 32'(s_ovld), 32'd0);
        chk("rst_in_ready", 32'(s_irdy), 32'd1);
        chk("rst_outputs", 32'(s_res), 32'd0);

        // Directed arithmetic corners
        run_one(16'h0001, 16'h0002, 1'b0, {1'b0, 1'b0, 16'h0003}, "add_small");
        run_one(16'hFFFF, 16'h0000, 1'b1, {1'b1, 1'b0, 16'h0000}, "carry_chain");
        run_one(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000}, "pos_ovf");
        run_one(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000}, "neg_ovf");

        // Back-to-back: 8 results in consecutive cycles
        mask = '0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) cycle(1'b1, 16'(i * 16'h1111), 16'(16'hF00F - i), i[0], 1'b1);
            else       idle(1'b1);
            mask[i] = s_ovld;
        end
        chk("b2b_valid_pattern", 32'(mask), 32'h0FF0);

        // Stall with full pipe
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h1234 * (i + 1)), 16'hABCD, 1'b1, 1'b0);
        idle(1'b0);
        snap = s_res;
        chk("stall_full_valid", 32'(s_ovld), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
            chk("stall_in_ready", 32'(s_irdy), 32'd0);
            chk("stall_frozen", 32'(s_res), 32'(snap));
        end
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (s_ovld) pops++;
        end
        chk("stall_drain_count", 32'(pops), 32'd4);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with 3 adds in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h5555, 16'(i), 1'b0, 1'b1);
        rst = 1'b1;
        idle(1'b1);
        rst = 1'b0;
        sb.delete();
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (s_ovld) pops++;
        end
        chk("rst_flush_no_stale", 32'(pops), 32'd0);

        // Random traffic
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            logic        iv;
            logic [15:0] ra;
            logic [15:0] rb;
            iv = ($urandom_range(0, 9) < 7);
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            cycle(iv, ra, rb, 1'($urandom), ($urandom_range(0, 9) < 7));
            if (iv && s_irdy) acc++;
            cyc++;
        end
        chk("rand_accepted", 32'(acc), 32'd10000);
        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("rand_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
